imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 156 +++++++++++++++
 tb/tb_imem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - instruction memory arbiter between the fetch port and the boot loader.
// Owns the single memory port. The loader has priority, but a fetch is
// guaranteed service after STARVE_LIMIT consecutive loader grants.
module imem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_BYTES    = 4096,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_req_addr,
  output logic                  fetch_req_ready,
  output logic                  fetch_rsp_valid,
  output logic [DATA_WIDTH-1:0] fetch_rsp_data,
  output logic                  fetch_rsp_err,
  input  logic                  fetch_rsp_ready,
  input  logic                  load_valid,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  input  logic                  load_done,
  output logic [15:0]           load_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {BOOT, IDLE, RESP} state_t;

  state_t                state_q, state_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [15:0]           load_count_q, load_count_d;
  logic [SW-1:0]         starve_q, starve_d;

  logic fetch_grant;
  logic load_grant;
  logic fetch_legal;
  logic load_legal;
  logic starve_full;
  logic load_write;

  // The +3 is done one bit wider so an address near the top of the space cannot wrap to legal.
  function automatic logic addr_legal(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] last;
    last = {1'b0, a} + (ADDR_WIDTH+1)'(3);
    return (a[1:0] == 2'b00) && (last < (ADDR_WIDTH+1)'(MEM_BYTES));
  endfunction

  always_comb begin
    fetch_legal  = addr_legal(fetch_req_addr);
    load_legal   = addr_legal(load_addr);
    starve_full  = (starve_q == SW'(STARVE_LIMIT));
    fetch_grant  = 1'b0;
    load_grant   = 1'b0;
    case (state_q)
      BOOT: load_grant = load_valid;
      IDLE: begin
        if (fetch_req_valid && (!load_valid || starve_full)) begin
          fetch_grant = 1'b1;
        end else begin
          load_grant = load_valid;
        end
      end
      RESP: load_grant = load_valid;
      default: begin
        fetch_grant = 1'b0;
        load_grant  = 1'b0;
      end
    endcase
    load_write = load_grant && load_legal;
  end

  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    load_count_d = load_count_q;
    starve_d     = starve_q;

    case (state_q)
      BOOT: begin
        if (load_done) state_d = IDLE;
      end
      IDLE: begin
        if (fetch_grant) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = fetch_legal ? mem_rdata : '0;
          rsp_err_d   = !fetch_legal;
        end
      end
      RESP: begin
        if (fetch_rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = BOOT;
        rsp_valid_d = 1'b0;
      end
    endcase

    if (load_write && (load_count_q != 16'hFFFF)) begin
      load_count_d = load_count_q + 16'd1;
    end

    // Loader grants in RESP also count, so fetch is never held off longer than STARVE_LIMIT grants.
    if (!fetch_req_valid || fetch_grant) begin
      starve_d = '0;
    end else if (load_grant && (state_q != BOOT) && !starve_full) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      load_count_q <= '0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      load_count_q <= load_count_d;
      starve_q     <= starve_d;
    end
  end

  // Handshake outputs are combinational; gating with rst_n keeps them quiet while in reset.
  assign fetch_req_ready = rst_n && fetch_grant;
  assign load_ready      = rst_n && load_grant;
  assign mem_we          = rst_n && load_write;
  assign mem_addr        = !rst_n      ? '0 :
                           fetch_grant ? fetch_req_addr :
                           load_grant  ? load_addr : '0;
  assign mem_wdata       = (rst_n && load_grant) ? load_data : '0;

  assign fetch_rsp_valid = rsp_valid_q;
  assign fetch_rsp_data  = rsp_data_q;
  assign fetch_rsp_err   = rsp_err_q;
  assign load_count      = load_count_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req_valid;
  logic [31:0] fetch_req_addr;
  logic        fetch_req_ready;
  logic        fetch_rsp_valid;
  logic [31:0] fetch_rsp_data;
  logic        fetch_rsp_err;
  logic        fetch_rsp_ready;
  logic        load_valid;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic [15:0] load_count;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];

  int errors = 0;
  int checks = 0;

  imem_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_req_valid (fetch_req_valid),
    .fetch_req_addr  (fetch_req_addr),
    .fetch_req_ready (fetch_req_ready),
    .fetch_rsp_valid (fetch_rsp_valid),
    .fetch_rsp_data  (fetch_rsp_data),
    .fetch_rsp_err   (fetch_rsp_err),
    .fetch_rsp_ready (fetch_rsp_ready),
    .load_valid      (load_valid),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .load_ready      (load_ready),
    .load_done       (load_done),
    .load_count      (load_count),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive at the falling edge, look at combinational outputs 1 ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
    step();
    fetch_req_valid = 1'b1; fetch_req_addr = addr; fetch_rsp_ready = 1'b0;
    #1;
    check("fetch_ready", {31'd0, fetch_req_ready}, 32'd1);
    check("fetch_mem_addr", mem_addr, addr);
    step();
    fetch_req_valid = 1'b0;
    #1;
    check("rsp_valid", {31'd0, fetch_rsp_valid}, 32'd1);
    check("rsp_data", fetch_rsp_data, exp_data);
    check("rsp_err", {31'd0, fetch_rsp_err}, {31'd0, exp_err});
    fetch_rsp_ready = 1'b1;
    step();
    fetch_rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_req_valid = 1'b0; fetch_req_addr = '0; fetch_rsp_ready = 1'b0;
    load_valid = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
    repeat (3) step();
    #1;
    check("rst_fetch_ready", {31'd0, fetch_req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, fetch_rsp_valid}, 32'd0);
    check("rst_rsp_data", fetch_rsp_data, 32'd0);
    check("rst_rsp_err", {31'd0, fetch_rsp_err}, 32'd0);
    check("rst_load_ready", {31'd0, load_ready}, 32'd0);
    check("rst_load_count", {16'd0, load_count}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);

    step();
    rst_n = 1'b1;
    fetch_req_valid = 1'b1; fetch_req_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check("boot_fetch_blocked", {31'd0, fetch_req_ready}, 32'd0);
    end

    step();
    fetch_req_valid = 1'b0;
    load_valid = 1'b1; load_addr = 32'h0; load_data = 32'h00500093;
    #1;
    check("boot_load_ready0", {31'd0, load_ready}, 32'd1);
    check("boot_mem_we0", {31'd0, mem_we}, 32'd1);
    check("boot_mem_addr0", mem_addr, 32'h0);
    check("boot_mem_wdata0", mem_wdata, 32'h00500093);
    step();
    load_addr = 32'h4; load_data = 32'h00A00113; load_done = 1'b1;
    #1;
    check("boot_mem_we1", {31'd0, mem_we}, 32'd1);
    check("boot_mem_addr1", mem_addr, 32'h4);
    step();
    load_valid = 1'b0; load_done = 1'b0;
    #1;
    check("boot_load_count", {16'd0, load_count}, 32'd2);
    check("idle_mem_we", {31'd0, mem_we}, 32'd0);

    // Fetch 0x4 and hold the response across a colliding loader write.
    fetch_req_valid = 1'b1; fetch_req_addr = 32'h4;
    #1;
    check("f4_ready", {31'd0, fetch_req_ready}, 32'd1);
    check("f4_mem_we", {31'd0, mem_we}, 32'd0);
    step();
    load_valid = 1'b1; load_addr = 32'h4; load_data = 32'hDEADBEEF;
    #1;
    check("f4_rsp_valid", {31'd0, fetch_rsp_valid}, 32'd1);
    check("f4_rsp_data", fetch_rsp_data, 32'h00A00113);
    check("f4_rsp_err", {31'd0, fetch_rsp_err}, 32'd0);
    check("resp_no_accept", {31'd0, fetch_req_ready}, 32'd0);
    check("resp_load_ready", {31'd0, load_ready}, 32'd1);
    check("resp_mem_we", {31'd0, mem_we}, 32'd1);
    step();
    load_valid = 1'b0;
    #1;
    check("f4_held_valid", {31'd0, fetch_rsp_valid}, 32'd1);
    check("f4_held_data", fetch_rsp_data, 32'h00A00113);
    fetch_rsp_ready = 1'b1;
    #1;
    check("rsp_ready_no_b2b", {31'd0, fetch_req_ready}, 32'd0);
    step();
    fetch_rsp_ready = 1'b0; fetch_req_valid = 1'b0;
    #1;
    check("rsp_released", {31'd0, fetch_rsp_valid}, 32'd0);
    check("count_after_resp_write", {16'd0, load_count}, 32'd3);

    // Legal boundary word, then illegal loader write beyond the memory.
    load_valid = 1'b1; load_addr = 32'hFFC; load_data = 32'h12345678;
    #1;
    check("ffc_mem_we", {31'd0, mem_we}, 32'd1);
    step();
    load_addr = 32'h1000; load_data = 32'hCAFEF00D;
    #1;
    check("oob_load_ready", {31'd0, load_ready}, 32'd1);
    check("oob_mem_we", {31'd0, mem_we}, 32'd0);
    step();
    load_valid = 1'b0;
    #1;
    check("oob_load_count", {16'd0, load_count}, 32'd4);

    do_fetch(32'hFFC, 32'h12345678, 1'b0);
    do_fetch(32'h6, 32'h0, 1'b1);
    do_fetch(32'hFFE, 32'h0, 1'b1);
    do_fetch(32'h1000, 32'h0, 1'b1);
    do_fetch(32'hFFFFFFFC, 32'h0, 1'b1);
    do_fetch(32'h0, 32'h00500093, 1'b0);

    // Both requesters continuously valid: fetch wins every fifth cycle.
    step();
    fetch_req_valid = 1'b1; fetch_req_addr = 32'h8; fetch_rsp_ready = 1'b1;
    load_valid = 1'b1; load_addr = 32'h100; load_data = 32'h11111111;
    for (int i = 0; i < 15; i++) begin
      #1;
      check("starve_fetch", {31'd0, fetch_req_ready}, {31'd0, (i % 5) == 4});
      check("starve_load", {31'd0, load_ready}, {31'd0, (i % 5) != 4});
      step();
    end
    fetch_req_valid = 1'b0; load_valid = 1'b0; fetch_rsp_ready = 1'b0;
    #1;
    check("starve_load_count", {16'd0, load_count}, 32'd16);

    // Reset in the middle of a held response.
    step();
    fetch_req_valid = 1'b1; fetch_req_addr = 32'h0;
    step();
    fetch_req_valid = 1'b0;
    #1;
    check("pre_reset_rsp_valid", {31'd0, fetch_rsp_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_rsp_valid", {31'd0, fetch_rsp_valid}, 32'd0);
    check("mid_reset_load_count", {16'd0, load_count}, 32'd0);
    check("mid_reset_rsp_data", fetch_rsp_data, 32'd0);
    step();
    rst_n = 1'b1; fetch_req_valid = 1'b1;
    step();
    #1;
    check("reboot_fetch_blocked", {31'd0, fetch_req_ready}, 32'd0);
    fetch_req_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
